stage_pipe_reg: RTL and testbench
=================================

# stage_pipe_reg

Parametrised inter-stage pipeline register for the five-stage core: the general replacement for the fixed-width stall-vector latches between EX/MEM/WB. It carries one writeback packet (opcode, destination register, value, write-enable) per cycle under a valid/ready handshake. An optional skid slot breaks the combinational ready path. It also supports synchronous flush and suppresses writes to x0.

## Interface
- `OPT_W`, 6: opcode field width
- `RD_W`, 5: destination register address width
- `DATA_W`, 32: register value width
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `rdy`  in  1  global chip-ready; low freezes all state
- `flush`  in  1  synchronous squash of all held packets
- `in_valid`  in  1  upstream packet present
- `in_ready`  out  1  block accepts packet this cycle
- `in_opt` / `in_rd` / `in_vd` / `in_we`  in  OPT_W / RD_W / DATA_W / 1  packet fields
- `out_valid`  out  1  packet presented downstream
- `out_ready`  in  1  downstream consumes packet
- `out_opt` / `out_rd` / `out_vd` / `out_we`  out  OPT_W / RD_W / DATA_W / 1  packet fields
- `occ`  out  2  number of packets held (0..2; max 1 without skid)

## Operation
- Accept: `in_valid && in_ready && rdy`. Consume: `out_valid && out_ready && rdy`.
- Main slot M drives `out_*`. Skid slot S holds an accepted packet while M is blocked.
- x0 rule: on capture, `we` is stored as `in_we && (in_rd != 0)`. `out_we` is never 1 with `out_rd == 0`.
- Accept with M empty, or M consumed in the same cycle, and S empty: the packet loads into M.
- Accept while M is full and not consumed: the packet loads into S.
- Consume with S full: S moves into M and S empties. If an accept happens in the same cycle, `in_ready` is 0 (S is full), so that combination cannot occur.
- Consume with S empty and no accept: M empties.
- Any slot that empties has all its fields cleared to 0. Invalid outputs therefore always read 0.
- `flush` (with `rdy` high): both slots are cleared to empty/zero. Any packet offered in that cycle is discarded even though `in_ready` may read 1. Flush has priority over accept and consume.
- `rdy` low: no register changes, including flush. `in_ready` is forced to 0 and `out_valid` is forced to 0. Payload outputs hold their values.
- Skid build: `in_ready = rdy && !S.valid`, taken from a register with no combinational path from `out_ready`.

## Timing
- Reset (`rst` low, asynchronous): M and S empty. `out_valid`, `out_opt`, `out_rd`, `out_vd`, `out_we` = 0. `occ` = 0. `in_ready` = `rdy` (1 when `rdy` is high).
- Reset released mid-stream: packets held before reset are lost. The first accept is allowed on the first rising edge with `rst` high.
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 packet per cycle while `out_ready` is held high.
- Backpressure: with skid, `in_ready` falls 1 cycle after the first blocked accept. At most 2 packets are held. Order is strictly FIFO.
- Simultaneous accept and consume with `occ` = 1: `occ` stays 1 and M takes the new packet.

## Configuration
- `STAGE_SKID_EN` defined: S slot present. `in_ready` is registered as above. `occ` ranges 0..2.
- `STAGE_SKID_EN` undefined: S removed. `in_ready = rdy && (!M.valid || out_ready)`, a combinational path. `occ[1]` is tied to 0.
- In both builds, flush, the x0 rule and `rdy` freeze behave identically.

## Structure
- Shared package/header `config.v` holds:
  - default widths `OptBus`, `RegAddrBus`, `RegBus`;
  - `Enable`/`Disable` constants;
  - packet field order (opt, rd, vd, we) for packing into one vector.
- Sub-module `stage_slot`: one valid bit plus a packet register, with `load`, `clear` and `rdy` inputs and asynchronous active-low reset. It is instantiated for M, and for S under `STAGE_SKID_EN`.

## Test plan
- Reset then stream: assert `rst` low mid-stream, release, drive packets rd=1..4 with vd=0x10..0x40 and `out_ready`=1. Expect zeros during reset, then outputs 1 cycle after each accept, with `occ` ≤ 1.
- Backpressure (skid build): drop `out_ready` for 3 cycles while `in_valid` stays 1. Expect `occ` to go 1→2, `in_ready`=0 on the following cycle, no loss or reorder, and drain order rd=5,6.
- x0 suppression: accept rd=0, we=1, vd=0xDEADBEEF. Expect `out_we`=0 and `out_rd`=0.
- Flush: with `occ`=2, pulse `flush` while offering a new packet. Next cycle expect `occ`=0, all outputs 0, and the offered packet never appears.
- `rdy` freeze: hold `rdy` low for 2 cycles with `occ`=1 while toggling `flush`, `in_valid` and `out_ready`. Expect `in_ready`=`out_valid`=0 and no state change. After `rdy` rises, the original packet is presented.
- Non-skid build: `out_ready`=0 with M full gives `in_ready`=0 in the same cycle. `out_ready`=1 gives simultaneous accept and consume.

Source files
------------

// File: rtl/stage_pipe_reg_pkg.sv
// Shared widths, flag constants and packet layout for the inter-stage pipeline register.
package stage_pipe_reg_pkg;

    // Default field widths
    localparam int unsigned OptBus     = 6;
    localparam int unsigned RegAddrBus = 5;
    localparam int unsigned RegBus     = 32;

    // Single-bit flag constants
    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

    // Packet field order when packed into one vector: {opt, rd, vd, we}
    typedef struct packed {
        logic [OptBus-1:0]     opt;
        logic [RegAddrBus-1:0] rd;
        logic [RegBus-1:0]     vd;
        logic                  we;
    } stage_pkt_t;

    localparam int unsigned PktBus = OptBus + RegAddrBus + RegBus + 1;

endpackage : stage_pipe_reg_pkg

// File: rtl/stage_slot.sv
// One pipeline slot: a valid bit plus a packed packet register.
// Clear beats load; nothing changes while rdy is low. An empty slot holds all-zero payload.
module stage_slot #(
    parameter int unsigned PKT_W = stage_pipe_reg_pkg::PktBus
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             load,
    input  logic             clear,
    input  logic [PKT_W-1:0] d,
    output logic             valid,
    output logic [PKT_W-1:0] q
);

    // Slot state: async reset to empty, clear/load gated by chip-ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (rdy) begin
            if (clear) begin
                valid <= 1'b0;
                q     <= '0;
            end else if (load) begin
                valid <= 1'b1;
                q     <= d;
            end
        end
    end

endmodule : stage_slot

// File: rtl/stage_pipe_reg.sv
// Inter-stage writeback pipeline register with valid/ready handshake, flush and x0 write suppression.
// Optional skid slot enabled by defining STAGE_SKID_EN (registered in_ready, up to 2 packets held).
module stage_pipe_reg
    import stage_pipe_reg_pkg::*;
#(
    parameter int unsigned OPT_W  = OptBus,
    parameter int unsigned RD_W   = RegAddrBus,
    parameter int unsigned DATA_W = RegBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPT_W-1:0]  in_opt,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_vd,
    input  logic              in_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPT_W-1:0]  out_opt,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_vd,
    output logic              out_we,
    output logic [1:0]        occ
);

    localparam int unsigned PKT_W = OPT_W + RD_W + DATA_W + 1;

    logic [PKT_W-1:0] in_pkt;
    logic [PKT_W-1:0] m_d;
    logic [PKT_W-1:0] m_q;
    logic             m_v;
    logic             m_load;
    logic             m_clear;
    logic             acc;
    logic             con;
    logic             flush_eff;

    // Capture-side packing; writes to x0 are dropped here so out_we can never pair with rd 0
    assign in_pkt    = {in_opt, in_rd, in_vd, in_we && (in_rd != '0)};
    assign acc       = in_valid && in_ready;
    assign con       = m_v && out_ready && rdy;
    assign flush_eff = flush && rdy;

`ifdef STAGE_SKID_EN
    logic [PKT_W-1:0] s_q;
    logic             s_v;
    logic             s_load;
    logic             s_clear;

    // Ready comes only from the skid register, breaking the path from out_ready
    assign in_ready = rdy && !s_v;

    // Slot control: S refills M on consume; new packets go to M if it frees up, else to S
    always_comb begin
        m_load  = (con && s_v) || (acc && (!m_v || con));
        m_d     = s_v ? s_q : in_pkt;
        m_clear = flush_eff || (con && !s_v && !acc);
        s_load  = acc && m_v && !con;
        s_clear = flush_eff || (con && s_v);
    end

    stage_slot #(.PKT_W(PKT_W)) u_slot_s (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .load  (s_load),
        .clear (s_clear),
        .d     (in_pkt),
        .valid (s_v),
        .q     (s_q)
    );

    // S is only ever full while M is full
    assign occ = {s_v, m_v && !s_v};
`else
    // Without a skid slot, ready must see same-cycle consumption
    assign in_ready = rdy && (!m_v || out_ready);

    // Slot control: accept always loads M; a consume with no replacement empties it
    always_comb begin
        m_load  = acc;
        m_d     = in_pkt;
        m_clear = flush_eff || (con && !acc);
    end

    assign occ = {1'b0, m_v};
`endif

    stage_slot #(.PKT_W(PKT_W)) u_slot_m (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .load  (m_load),
        .clear (m_clear),
        .d     (m_d),
        .valid (m_v),
        .q     (m_q)
    );

    // Downstream view: valid masked by chip-ready, payload straight from the M register
    assign out_valid = m_v && rdy;
    assign {out_opt, out_rd, out_vd, out_we} = m_q;

endmodule : stage_pipe_reg

// File: tb/tb_stage_pipe_reg.sv
// Directed, table-driven bench for stage_pipe_reg (works for both skid and non-skid builds).
module tb_stage_pipe_reg;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opt;
    logic [4:0]  in_rd;
    logic [31:0] in_vd;
    logic        in_we;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_opt;
    logic [4:0]  out_rd;
    logic [31:0] out_vd;
    logic        out_we;
    logic [1:0]  occ;

    int checks = 0;
    int errors = 0;

    stage_pipe_reg dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opt    (in_opt),
        .in_rd     (in_rd),
        .in_vd     (in_vd),
        .in_we     (in_we),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_opt   (out_opt),
        .out_rd    (out_rd),
        .out_vd    (out_vd),
        .out_we    (out_we),
        .occ       (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        fl;
        logic        iv;
        logic [5:0]  opt;
        logic [4:0]  rd;
        logic [31:0] vd;
        logic        we;
        logic        ordy;
        logic        ir_ns;   // expected in_ready before the edge, non-skid build
        logic        ir_sk;   // expected in_ready before the edge, skid build
        logic        ov;
        logic [5:0]  e_opt;
        logic [4:0]  e_rd;
        logic [31:0] e_vd;
        logic        e_we;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic fl, input logic iv, input logic [5:0] opt,
                         input logic [4:0] rd, input logic [31:0] vd, input logic we, input logic ordy);
        rdy = r; flush = fl; in_valid = iv; in_opt = opt;
        in_rd = rd; in_vd = vd; in_we = we; out_ready = ordy;
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic [5:0] opt, input logic [4:0] rd,
                           input logic [31:0] vd, input logic we, input logic [1:0] oc);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".out_opt"},   32'(out_opt),   32'(opt));
        chk({tag, ".out_rd"},    32'(out_rd),    32'(rd));
        chk({tag, ".out_vd"},    out_vd,         vd);
        chk({tag, ".out_we"},    32'(out_we),    32'(we));
        chk({tag, ".occ"},       32'(occ),       32'(oc));
    endtask

    function automatic vec_t mk(input logic r, input logic fl, input logic iv, input logic [5:0] opt,
                                input logic [4:0] rd, input logic [31:0] vd, input logic we, input logic ordy,
                                input logic ir_ns, input logic ir_sk, input logic ov, input logic [5:0] e_opt,
                                input logic [4:0] e_rd, input logic [31:0] e_vd, input logic e_we,
                                input logic [1:0] e_occ);
        vec_t v;
        v.rdy = r; v.fl = fl; v.iv = iv; v.opt = opt; v.rd = rd; v.vd = vd; v.we = we; v.ordy = ordy;
        v.ir_ns = ir_ns; v.ir_sk = ir_sk; v.ov = ov; v.e_opt = e_opt; v.e_rd = e_rd;
        v.e_vd = e_vd; v.e_we = e_we; v.e_occ = e_occ;
        return v;
    endfunction

    initial begin
        logic exp_ir;
        //             rdy fl iv opt rd  vd            we or | irn irs ov opt rd  vd            we occ
        vecs.push_back(mk(1, 0, 1, 1,  1,  32'h10,       1, 1,  1, 1, 1, 1,  1,  32'h10,       1, 1));
        vecs.push_back(mk(1, 0, 1, 2,  2,  32'h20,       1, 1,  1, 1, 1, 2,  2,  32'h20,       1, 1));
        vecs.push_back(mk(1, 0, 1, 3,  3,  32'h30,       1, 1,  1, 1, 1, 3,  3,  32'h30,       1, 1));
        vecs.push_back(mk(1, 0, 1, 4,  4,  32'h40,       1, 1,  1, 1, 1, 4,  4,  32'h40,       1, 1));
        vecs.push_back(mk(1, 0, 0, 0,  0,  32'h0,        0, 1,  1, 1, 0, 0,  0,  32'h0,        0, 0));
        vecs.push_back(mk(1, 0, 1, 5,  0,  32'hDEADBEEF, 1, 0,  1, 1, 1, 5,  0,  32'hDEADBEEF, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0,  0,  32'h0,        0, 0,  0, 1, 1, 5,  0,  32'hDEADBEEF, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0,  0,  32'h0,        0, 1,  1, 1, 0, 0,  0,  32'h0,        0, 0));
        vecs.push_back(mk(1, 0, 1, 3,  7,  32'h77,       0, 0,  1, 1, 1, 3,  7,  32'h77,       0, 1));
        vecs.push_back(mk(0, 1, 1, 9,  9,  32'h99,       1, 1,  0, 0, 0, 3,  7,  32'h77,       0, 1));
        vecs.push_back(mk(0, 0, 0, 0,  0,  32'h0,        0, 0,  0, 0, 0, 3,  7,  32'h77,       0, 1));
        vecs.push_back(mk(1, 0, 0, 0,  0,  32'h0,        0, 0,  0, 1, 1, 3,  7,  32'h77,       0, 1));
        vecs.push_back(mk(1, 1, 1, 8,  8,  32'h88,       1, 1,  1, 1, 0, 0,  0,  32'h0,        0, 0));
        vecs.push_back(mk(1, 0, 0, 0,  0,  32'h0,        0, 1,  1, 1, 0, 0,  0,  32'h0,        0, 0));
        vecs.push_back(mk(1, 0, 1, 63, 31, 32'hFFFFFFFF, 1, 1,  1, 1, 1, 63, 31, 32'hFFFFFFFF, 1, 1));
        vecs.push_back(mk(1, 0, 1, 6,  0,  32'h1,        1, 1,  1, 1, 1, 6,  0,  32'h1,        0, 1));
        vecs.push_back(mk(1, 0, 0, 0,  0,  32'h0,        0, 1,  1, 1, 0, 0,  0,  32'h0,        0, 0));

        // Reset state
        rst = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 0, 0, 0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven vectors
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rdy, vecs[i].fl, vecs[i].iv, vecs[i].opt, vecs[i].rd, vecs[i].vd,
                  vecs[i].we, vecs[i].ordy);
            #1;
`ifdef STAGE_SKID_EN
            exp_ir = vecs[i].ir_sk;
`else
            exp_ir = vecs[i].ir_ns;
`endif
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(exp_ir));
            @(posedge clk);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].ov, vecs[i].e_opt, vecs[i].e_rd,
                    vecs[i].e_vd, vecs[i].e_we, vecs[i].e_occ);
        end

        // Reset asserted mid-stream: held packet lost, no accept while in reset
        @(negedge clk);
        drive(1, 0, 1, 6, 6, 32'h60, 1, 0);
        @(posedge clk);
        #1;
        chk_out("pre_rst", 1, 6, 6, 32'h60, 1, 1);
        #2;
        rst = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0, 0, 0, 0);
        chk("async_rst.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk_out("in_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 1, 1, 1, 32'h10, 1, 1);
        @(posedge clk);
        #1;
        chk_out("post_rst", 1, 1, 1, 32'h10, 1, 1);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        chk_out("post_rst_drain", 0, 0, 0, 0, 0, 0);

`ifdef STAGE_SKID_EN
        // Backpressure: out_ready low for 3 cycles with in_valid held high
        @(negedge clk);
        drive(1, 0, 1, 5, 5, 32'h50, 1, 1);
        @(posedge clk); #1;
        chk_out("bp0", 1, 5, 5, 32'h50, 1, 1);
        @(negedge clk);
        drive(1, 0, 1, 6, 6, 32'h60, 1, 0);
        #1;
        chk("bp1.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk_out("bp1", 1, 5, 5, 32'h50, 1, 2);
        chk("bp1.in_ready_after", 32'(in_ready), 32'd0);
        for (int k = 2; k <= 3; k++) begin
            @(negedge clk);
            drive(1, 0, 1, 7, 7, 32'h70, 1, 0);
            #1;
            chk($sformatf("bp%0d.in_ready", k), 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            chk_out($sformatf("bp%0d", k), 1, 5, 5, 32'h50, 1, 2);
        end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk); #1;
        chk_out("drain5", 1, 6, 6, 32'h60, 1, 1);
        @(posedge clk); #1;
        chk_out("drain6", 0, 0, 0, 0, 0, 0);

        // Flush with two packets held and a new one offered
        @(negedge clk);
        drive(1, 0, 1, 1, 10, 32'hA0, 1, 0);
        @(posedge clk); #1;
        @(negedge clk);
        drive(1, 0, 1, 1, 11, 32'hB0, 1, 0);
        @(posedge clk); #1;
        chk("fl_pre.occ", 32'(occ), 32'd2);
        @(negedge clk);
        drive(1, 1, 1, 1, 12, 32'hC0, 1, 0);
        @(posedge clk); #1;
        chk_out("flush", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk); #1;
        chk_out("flush_after", 0, 0, 0, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_stage_pipe_reg
